// File: rtl/riscv_core_mul_iter.sv
// Iterative unsigned magnitude multiplier feeding the M-extension output stage.
// Define MUL_RADIX4_EN to retire two multiplier bits per cycle (radix-4) instead of one.
module riscv_core_mul_iter #(
  parameter int XLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_mul_valid,
  output logic                o_mul_ready,
  input  logic [XLEN-1:0]     i_mul_srcA,
  input  logic [XLEN-1:0]     i_mul_srcB,
  input  logic [1:0]          i_mul_control,
  input  logic                i_mul_isword,
  input  logic                i_mul_flush,
  output logic                o_mul_valid,
  input  logic                i_mul_ready,
  output logic [2*XLEN-1:0]   o_mul_product,
  output logic                o_mul_srcA_Dsign,
  output logic                o_mul_srcB_Dsign,
  output logic                o_mul_srcA_Wsign,
  output logic                o_mul_srcB_Wsign,
  output logic [1:0]          o_mul_control,
  output logic                o_mul_isword
);

  localparam int HALF = XLEN / 2;
`ifdef MUL_RADIX4_EN
  localparam int K = XLEN / 2;
`else
  localparam int K = XLEN;
`endif
  localparam int CW = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state_reg;
  logic                ready_reg;
  logic                valid_reg;
  logic [2*XLEN-1:0]   product_reg;
  logic                dsign_a_reg, dsign_b_reg, wsign_a_reg, wsign_b_reg;
  logic [1:0]          control_reg;
  logic                isword_reg;
  logic [2*XLEN-1:0]   mcand_reg;
  logic [XLEN-1:0]     mplier_reg;
  logic [2*XLEN-1:0]   acc_reg;
  logic [CW-1:0]       cnt_reg;

  logic                accept;
  logic                dsign_a_next, dsign_b_next, wsign_a_next, wsign_b_next;
  logic [XLEN-1:0]     mag_a_next, mag_b_next;
  logic [HALF-1:0]     lo_a, lo_b;
  logic [2*XLEN-1:0]   addend;
  logic [2*XLEN-1:0]   acc_next;
  logic [2*XLEN-1:0]   mcand_next;
  logic [XLEN-1:0]     mplier_next;

  // A flush in the accept cycle suppresses the accept.
  assign accept = i_mul_valid && ready_reg && !i_mul_flush;

  assign lo_a = i_mul_srcA[HALF-1:0];
  assign lo_b = i_mul_srcB[HALF-1:0];

  assign dsign_a_next = !i_mul_isword && (i_mul_control != 2'b11) && i_mul_srcA[XLEN-1];
  assign dsign_b_next = !i_mul_isword && !i_mul_control[1] && i_mul_srcB[XLEN-1];
  assign wsign_a_next = i_mul_isword && lo_a[HALF-1];
  assign wsign_b_next = i_mul_isword && lo_b[HALF-1];

  always_comb begin
    mag_a_next = i_mul_srcA;
    mag_b_next = i_mul_srcB;
    if (i_mul_isword) begin
      mag_a_next = {{HALF{1'b0}}, (wsign_a_next ? ({HALF{1'b0}} - lo_a) : lo_a)};
      mag_b_next = {{HALF{1'b0}}, (wsign_b_next ? ({HALF{1'b0}} - lo_b) : lo_b)};
    end else begin
      if (dsign_a_next) mag_a_next = {XLEN{1'b0}} - i_mul_srcA;
      if (dsign_b_next) mag_b_next = {XLEN{1'b0}} - i_mul_srcB;
    end
  end

`ifdef MUL_RADIX4_EN
  always_comb begin
    addend = '0;
    case (mplier_reg[1:0])
      2'b01:   addend = mcand_reg;
      2'b10:   addend = mcand_reg << 1;
      2'b11:   addend = mcand_reg + (mcand_reg << 1);
      default: addend = '0;
    endcase
  end
  assign mcand_next  = mcand_reg << 2;
  assign mplier_next = mplier_reg >> 2;
`else
  assign addend      = mplier_reg[0] ? mcand_reg : '0;
  assign mcand_next  = mcand_reg << 1;
  assign mplier_next = mplier_reg >> 1;
`endif

  assign acc_next = acc_reg + addend;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg   <= IDLE;
      ready_reg   <= 1'b1;
      valid_reg   <= 1'b0;
      product_reg <= '0;
      dsign_a_reg <= 1'b0;
      dsign_b_reg <= 1'b0;
      wsign_a_reg <= 1'b0;
      wsign_b_reg <= 1'b0;
      control_reg <= 2'b00;
      isword_reg  <= 1'b0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            dsign_a_reg <= dsign_a_next;
            dsign_b_reg <= dsign_b_next;
            wsign_a_reg <= wsign_a_next;
            wsign_b_reg <= wsign_b_next;
            control_reg <= i_mul_control;
            isword_reg  <= i_mul_isword;
            mcand_reg   <= {{XLEN{1'b0}}, mag_a_next};
            mplier_reg  <= mag_b_next;
            acc_reg     <= '0;
            cnt_reg     <= CW'(K);
            ready_reg   <= 1'b0;
            if (mag_a_next == '0 || mag_b_next == '0) begin
              product_reg <= '0;
              state_reg   <= DONE;
            end else begin
              state_reg   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (i_mul_flush) begin
            state_reg <= IDLE;
            ready_reg <= 1'b1;
          end else begin
            acc_reg    <= acc_next;
            mcand_reg  <= mcand_next;
            mplier_reg <= mplier_next;
            cnt_reg    <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
              product_reg <= acc_next;
              state_reg   <= DONE;
            end
          end
        end
        DONE: begin
          // valid rises on the first DONE cycle so latency is K+1 (or 1 on the zero path)
          if (i_mul_flush) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end else if (!valid_reg) begin
            valid_reg <= 1'b1;
          end else if (i_mul_ready) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign o_mul_ready      = ready_reg;
  assign o_mul_valid      = valid_reg;
  assign o_mul_product    = product_reg;
  assign o_mul_srcA_Dsign = dsign_a_reg;
  assign o_mul_srcB_Dsign = dsign_b_reg;
  assign o_mul_srcA_Wsign = wsign_a_reg;
  assign o_mul_srcB_Wsign = wsign_b_reg;
  assign o_mul_control    = control_reg;
  assign o_mul_isword     = isword_reg;

endmodule

// File: tb/tb_riscv_core_mul_iter.sv
// Scoreboard bench for riscv_core_mul_iter: directed ops, flush, back-pressure and reset cases.
module tb_riscv_core_mul_iter;
  localparam int XLEN = 32;
`ifdef MUL_RADIX4_EN
  localparam int K = XLEN / 2;
`else
  localparam int K = XLEN;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, out_ready_dut, out_valid, down_ready, flush, isword;
  logic [31:0] src_a, src_b;
  logic [1:0]  control;
  logic [63:0] product;
  logic        da, db, wa, wb;
  logic [1:0]  control_q;
  logic        isword_q;

  always #5 clk = ~clk;

  riscv_core_mul_iter #(.XLEN(XLEN)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_mul_valid(in_valid), .o_mul_ready(out_ready_dut),
    .i_mul_srcA(src_a), .i_mul_srcB(src_b),
    .i_mul_control(control), .i_mul_isword(isword), .i_mul_flush(flush),
    .o_mul_valid(out_valid), .i_mul_ready(down_ready),
    .o_mul_product(product),
    .o_mul_srcA_Dsign(da), .o_mul_srcB_Dsign(db),
    .o_mul_srcA_Wsign(wa), .o_mul_srcB_Wsign(wb),
    .o_mul_control(control_q), .o_mul_isword(isword_q)
  );

  typedef struct {
    logic [63:0] prod;
    logic        da, db, wa, wb;
    logic [1:0]  ctrl;
    logic        isw;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(logic [63:0] p, logic a_d, logic b_d, logic a_w, logic b_w,
                              logic [1:0] c, logic w, int lat);
    exp_t e;
    e.prod = p; e.da = a_d; e.db = b_d; e.wa = a_w; e.wb = b_w;
    e.ctrl = c; e.isw = w; e.lat = lat;
    return e;
  endfunction

  // Reference: signed-value magnitudes via 2^N - x, product in 64-bit arithmetic
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] c, logic w);
    exp_t e;
    longint unsigned ma, mb;
    e.ctrl = c; e.isw = w;
    if (w) begin
      e.da = 0; e.db = 0;
      e.wa = a[15]; e.wb = b[15];
      ma = e.wa ? (64'h10000 - {48'h0, a[15:0]}) : {48'h0, a[15:0]};
      mb = e.wb ? (64'h10000 - {48'h0, b[15:0]}) : {48'h0, b[15:0]};
    end else begin
      e.wa = 0; e.wb = 0;
      e.da = (c == 2'd0 || c == 2'd1 || c == 2'd2) && a[31];
      e.db = (c == 2'd0 || c == 2'd1) && b[31];
      ma = e.da ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
      mb = e.db ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
    end
    e.prod = ma * mb;
    e.lat = (ma == 0 || mb == 0) ? 1 : K + 1;
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] c, input logic w, input exp_t e, input int hold);
    exp_t got;
    int cyc;
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_ready_idle"}, {63'h0, out_ready_dut}, 64'd1);
    in_valid = 1; src_a = a; src_b = b; control = c; isword = w;
    @(posedge clk); #1;
    in_valid = 0;
    chk({tag, "_ready_low"}, {63'h0, out_ready_dut}, 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
    end
    got = sb.pop_front();
    chk({tag, "_latency"}, 64'(cyc), 64'(got.lat));
    chk({tag, "_product"}, product, got.prod);
    chk({tag, "_flags"}, {60'h0, da, db, wa, wb}, {60'h0, got.da, got.db, got.wa, got.wb});
    chk({tag, "_ctrl"}, {61'h0, control_q, isword_q}, {61'h0, got.ctrl, got.isw});
    repeat (hold) begin
      @(posedge clk); #1;
      chk({tag, "_hold"}, {out_valid, out_ready_dut, product[61:0]}, {1'b1, 1'b0, got.prod[61:0]});
    end
    @(negedge clk);
    down_ready = 1;
    @(posedge clk); #1;
    down_ready = 0;
    chk({tag, "_handshake"}, {62'h0, out_valid, out_ready_dut}, 64'b01);
    $display("op %s a=%h b=%h ctrl=%0d w=%0d product=%h lat=%0d", tag, a, b, c, w, product, cyc);
  endtask

  task automatic start_only(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1; src_a = a; src_b = b; control = 2'd3; isword = 0;
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    rst_n = 0; in_valid = 0; flush = 0; down_ready = 0;
    src_a = '0; src_b = '0; control = '0; isword = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {out_valid, out_ready_dut, da, db, wa, wb, control_q, isword_q},
        {1'b0, 1'b1, 7'b0});
    chk("reset_product", product, 64'h0);
    $display("reset checked");
    rst_n = 1;

    run_op("mul_neg3x7", 32'hFFFFFFFD, 32'h7, 2'd0, 0,
           mk(64'h15, 1, 0, 0, 0, 2'd0, 0, K + 1), 0);
    run_op("mulhu_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 0,
           mk(64'hFFFFFFFE00000001, 0, 0, 0, 0, 2'd3, 0, K + 1), 0);
    run_op("mulhsu_min", 32'h80000000, 32'h2, 2'd2, 0,
           mk(64'h0000000100000000, 1, 0, 0, 0, 2'd2, 0, K + 1), 0);
    run_op("mulw", 32'h1234FFFF, 32'h3, 2'd0, 1,
           mk(64'h3, 0, 0, 1, 0, 2'd0, 1, K + 1), 0);
    run_op("zero_b", 32'h5, 32'h0, 2'd0, 0,
           mk(64'h0, 0, 0, 0, 0, 2'd0, 0, 1), 0);
    run_op("mulh_minmin", 32'h80000000, 32'h80000000, 2'd1, 0,
           mk(64'h4000000000000000, 1, 1, 0, 0, 2'd1, 0, K + 1), 4);
    run_op("zero_a_hold", 32'h0, 32'hDEADBEEF, 2'd3, 0,
           mk(64'h0, 0, 0, 0, 0, 2'd3, 0, 1), 3);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra, rb;
      logic [1:0]  rc;
      logic        rw;
      ra = $urandom; rb = $urandom; rc = 2'($urandom_range(0, 3)); rw = (i % 3 == 2);
      run_op($sformatf("rand%0d", i), ra, rb, rc, rw, model(ra, rb, rc, rw), i % 2);
    end

    // flush during BUSY cycle 5
    start_only(32'h12345678, 32'h9ABCDEF1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush_busy_ready", {62'h0, out_valid, out_ready_dut}, 64'b01);
    seen = 0;
    repeat (K + 4) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_busy_no_valid", 64'(seen), 64'd0);
    $display("flush in busy checked");

    // flush while waiting in DONE
    start_only(32'h3, 32'h5);
    repeat (K + 1) @(posedge clk);
    #1;
    chk("flush_done_pre_valid", {63'h0, out_valid}, 64'd1);
    @(negedge clk);
    flush = 1; down_ready = 1;
    @(posedge clk); #1;
    flush = 0; down_ready = 0;
    chk("flush_done", {62'h0, out_valid, out_ready_dut}, 64'b01);
    $display("flush in done checked");

    // flush coincident with a request blocks the accept
    @(negedge clk);
    in_valid = 1; flush = 1; src_a = 32'h7; src_b = 32'h9; control = 2'd3; isword = 0;
    @(posedge clk); #1;
    in_valid = 0; flush = 0;
    chk("flush_accept_blocked", {63'h0, out_ready_dut}, 64'd1);
    seen = 0;
    repeat (K + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    chk("flush_accept_no_valid", 64'(seen), 64'd0);
    $display("flush with accept checked");

    // reset in BUSY
    start_only(32'hFFFF0000, 32'h00010001);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    chk("reset_busy", {out_valid, out_ready_dut, da, db, wa, wb, control_q, isword_q},
        {1'b0, 1'b1, 7'b0});
    rst_n = 1;
    $display("reset in busy checked");

    run_op("after_reset", 32'h10, 32'h20, 2'd3, 0,
           mk(64'h200, 0, 0, 0, 0, 2'd3, 0, K + 1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/riscv_core_mul_iter.md
# riscv_core_mul_iter

Iterative unsigned multiplier that sits directly upstream of the M-extension output stage (`riscv_core_mul_out`).
- Converts each operand to a magnitude according to the MUL/MULH/MULHSU/MULHU/MULW encoding and multiplies the magnitudes over several cycles.
- Delivers the full 2*XLEN-bit unsigned product together with the operand sign flags, control and isword. The output stage applies the sign correction and selects the result half.
- Valid/ready handshakes on both sides let the execute stage stall on it; a flush input kills an in-flight operation.

## Interface
- XLEN, 32, operand width; must be even.
- i_clk  in  1  clock, all state updates on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_mul_valid  in  1  request valid.
- o_mul_ready  out  1  block can accept a request; high only in IDLE.
- i_mul_srcA  in  XLEN  operand A (rs1).
- i_mul_srcB  in  XLEN  operand B (rs2).
- i_mul_control  in  2  00 MUL/MULW, 01 MULH, 10 MULHSU, 11 MULHU.
- i_mul_isword  in  1  word operation (low XLEN/2 bits).
- i_mul_flush  in  1  abort current operation.
- o_mul_valid  out  1  product valid.
- i_mul_ready  in  1  downstream accepts product.
- o_mul_product  out  2*XLEN  unsigned product of magnitudes.
- o_mul_srcA_Dsign, o_mul_srcB_Dsign  out  1 each  full-width sign flags.
- o_mul_srcA_Wsign, o_mul_srcB_Wsign  out  1 each  word sign flags.
- o_mul_control  out  2  registered copy of i_mul_control.
- o_mul_isword  out  1  registered copy of i_mul_isword.

## Operation
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> BUSY on i_mul_valid && o_mul_ready.
  - BUSY -> DONE when the iteration count is exhausted.
  - DONE -> IDLE on i_mul_ready.
- On accept, the operands, control and isword are latched and signs computed:
  - Dsign A = srcA[XLEN-1] when control is MUL, MULH or MULHSU, else 0.
  - Dsign B = srcB[XLEN-1] when control is MUL or MULH, else 0.
  - Wsign A/B = srcA/srcB[XLEN/2-1] when isword, else 0.
  - Dsign A/B are forced to 0 when isword.
- Magnitudes:
  - Non-word: two's-complement negation of an operand whose Dsign is set, else the raw operand.
  - Word: the low XLEN/2 bits, negated when the Wsign is set, zero-extended to XLEN.
  - 0x80000000 (XLEN=32) yields magnitude 0x80000000, unsigned; no overflow.
- BUSY performs shift-add over the multiplier magnitude into a 2*XLEN accumulator. The accumulator is cleared on accept.
- Zero fast path: if either magnitude is 0, go IDLE -> DONE directly with o_mul_product = 0.
- DONE: all o_mul_* outputs stay stable until the handshake completes.
- Flush: i_mul_flush in BUSY or DONE returns to IDLE next cycle and drops o_mul_valid. Flush has priority over i_mul_ready and over completion, and is ignored in IDLE. Flush in the same cycle as an accept blocks the accept.
- Reset values: FSM IDLE, o_mul_valid 0, o_mul_ready 1, o_mul_product 0, all sign flags 0, o_mul_control 00, o_mul_isword 0.

## Timing
- Accept at edge N. BUSY lasts K cycles, where K = XLEN/2 (radix-4) or XLEN (radix-2).
- o_mul_valid rises at edge N+K+1.
- Zero fast path: o_mul_valid rises at edge N+1.
- o_mul_ready is low from edge N until the edge after the DONE handshake; no back-to-back accept in the handoff cycle.
- Reset asserted in any state takes effect at the next edge and overrides flush and handshakes.

## Configuration
- MUL_RADIX4_EN defined:
  - Two multiplier bits retired per cycle, adding 0, 1, 2 or 3 times the multiplicand.
  - K = XLEN/2 (16 for XLEN=32).
- Undefined:
  - One bit per cycle, adding 0 or 1 times the multiplicand.
  - K = XLEN (32).
- Products, flags and the handshake are identical in both builds; only latency differs.

## Test plan
- MUL srcA=0xFFFFFFFD (-3), srcB=7 -> product 0x0000000000000015, Dsign A=1, B=0; valid after K+1 cycles.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> product 0xFFFFFFFE00000001, all flags 0.
- MULHSU srcA=0x80000000, srcB=0x00000002 -> product 0x0000000100000000, Dsign A=1, B=0.
- MULW (isword=1) srcA=0x1234FFFF, srcB=0x00000003 -> product 0x3, Wsign A=1, B=0, Dsign both 0.
- srcB=0 -> valid one cycle after accept, product 0.
- Flush at BUSY cycle 5 -> valid never rises and ready returns next cycle. Separately, hold i_mul_ready=0 for 4 cycles in DONE -> outputs stable, then IDLE after the handshake.
